// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: field widths,
// ALU op codes, opcode/funct constants, state encoding and the control word.
package multicycle_control_pkg;

    localparam int OPC_W   = 6;
    localparam int FUNCT_W = 6;
    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    // Everything the FSM drives into the datapath in one cycle.
    typedef struct packed {
        logic               pc_en;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic               ext_zero;
        logic [1:0]         pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
        logic               retired;
    } ctrl_t;

    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

    function automatic logic is_imm_alu(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_SLTI);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_control.sv
// Combinational ALU decoder: maps opcode/funct to the ALU op code, flags
// unsupported encodings and selects zero-extension for logical immediates.
module alu_control
    import multicycle_control_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               legal,
    output logic               ext_zero
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        alu_op   = ALU_ADD;
        legal    = 1'b1;
        ext_zero = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_J, OP_ADDI: alu_op = ALU_ADD;
            OP_BEQ, OP_BNE:              alu_op = ALU_SUB;
            OP_ANDI: begin
                alu_op   = ALU_AND;
                ext_zero = 1'b1;
            end
            OP_ORI: begin
                alu_op   = ALU_OR;
                ext_zero = 1'b1;
            end
            OP_SLTI: alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Moore outputs per state;
// branch resolution uses the ALU zero flag in the BRANCH state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               alu_zero,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               retired,
    output logic [3:0]         state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_legal;
    logic               dec_ext_zero;

    alu_control u_alu_control (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal),
        .ext_zero (dec_ext_zero)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = ctrl_default();
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_en     = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                if (!dec_legal) begin
                    ctrl.illegal = 1'b1;
                    state_d      = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (is_imm_alu(opcode)) begin
                    state_d = S_IEXEC;
                end
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retired    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retired   = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = dec_alu_op;
                state_d        = S_RWB;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retired   = 1'b1;
            end
            S_BRANCH: begin
                // opcode is held by IR, so beq/bne is still known here.
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_en     = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
                ctrl.retired   = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
                ctrl.retired   = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = dec_alu_op;
                ctrl.ext_zero  = dec_ext_zero;
                state_d        = S_IWB;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retired   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes are masked during reset so a mid-instruction reset cannot
        // write memory or registers in the cycle it is raised.
        if (reset) begin
            ctrl.pc_en     = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.illegal   = 1'b0;
            ctrl.retired   = 1'b0;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign ext_zero   = ctrl.ext_zero;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;
    assign retired    = ctrl.retired;
    assign state      = state_q;

endmodule
